// File: rtl/seg_pkg.sv
// Shared display-code constants and controller state encoding for the seven-segment scan path.
package seg_pkg;

  localparam logic [4:0] CODE_L     = 5'h10;
  localparam logic [4:0] CODE_D     = 5'h11;
  localparam logic [4:0] CODE_P     = 5'h12;
  localparam logic [4:0] CODE_N     = 5'h13;
  localparam logic [4:0] CODE_DASH  = 5'h14;
  localparam logic [4:0] CODE_BLANK = 5'h15;
  localparam logic [4:0] CODE_MAX   = 5'h15;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] SHOW  = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;

  // Unassigned codes render as blank rather than garbage.
  function automatic logic [4:0] sanitize_code(input logic [4:0] code);
    return (code > CODE_MAX) ? CODE_BLANK : code;
  endfunction

endpackage

// File: rtl/binaryToSegment.sv
// Display-code to seven-segment decoder; output is active-low {a,b,c,d,e,f,g}.
module binaryToSegment
  import seg_pkg::*;
(
  input  logic [4:0] bin,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (bin)
      5'h00:      seg = 7'b0000001;
      5'h01:      seg = 7'b1001111;
      5'h02:      seg = 7'b0010010;
      5'h03:      seg = 7'b0000110;
      5'h04:      seg = 7'b1001100;
      5'h05:      seg = 7'b0100100;
      5'h06:      seg = 7'b0100000;
      5'h07:      seg = 7'b0001111;
      5'h08:      seg = 7'b0000000;
      5'h09:      seg = 7'b0000100;
      5'h0A:      seg = 7'b0001000;
      5'h0B:      seg = 7'b1100000;
      5'h0C:      seg = 7'b0110001;
      5'h0D:      seg = 7'b1000010;
      5'h0E:      seg = 7'b0110000;
      5'h0F:      seg = 7'b0111000;
      CODE_L:     seg = 7'b1110001;
      CODE_D:     seg = 7'b1000010;
      CODE_P:     seg = 7'b0011000;
      CODE_N:     seg = 7'b1101010;
      CODE_DASH:  seg = 7'b1111110;
      CODE_BLANK: seg = 7'b1111111;
      default:    seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan controller: buffers an 8-character message and shows a scrolling
// 4-character window on a common-anode seven-segment display.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned MSG_LEN       = 8,
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter int unsigned SCROLL_FRAMES = 50
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   msg_valid,
  output logic                   msg_ready,
  input  logic [5*MSG_LEN-1:0]   msg_data,
  input  logic                   scroll_en,
  input  logic                   blank_all,
  output logic [NUM_DIGITS-1:0]  an,
  output logic [6:0]             seg,
  output logic                   frame_tick
);

  localparam int unsigned RefW = $clog2(REFRESH_DIV);
  localparam int unsigned DigW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned OffW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int unsigned FrmW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  logic [1:0]            state_q, state_d;
  logic [RefW-1:0]       refresh_q, refresh_d;
  logic [DigW-1:0]       digit_q, digit_d;
  logic [FrmW-1:0]       frame_q, frame_d;
  logic [OffW-1:0]       offset_q, offset_d;
  logic [4:0]            buf_q [MSG_LEN];
  logic                  ready_q, ready_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q;
  logic                  tick_q;

  logic                  accept;
  logic                  slot_end;
  logic                  frame_wrap;
  logic [OffW-1:0]       sel;
  logic [4:0]            code;
  logic [6:0]            seg_dec;

  assign accept     = msg_valid && ready_q;
  assign slot_end   = (refresh_q == RefW'(REFRESH_DIV - 1));
  assign frame_wrap = slot_end && (digit_q == '0);

  always_comb begin
    refresh_d = slot_end ? '0 : refresh_q + RefW'(1);
    digit_d   = digit_q;
    if (slot_end) begin
      digit_d = frame_wrap ? DigW'(NUM_DIGITS - 1) : digit_q - DigW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = LOAD;
      SHOW:    if (accept) state_d = LOAD;
      LOAD:    state_d = SHOW;
      default: state_d = EMPTY;
    endcase
    // LOAD blocks a back-to-back accept; ready returns the cycle after.
    ready_d = !accept;
  end

  // An accept takes priority over a scroll step landing on the same edge.
  always_comb begin
    frame_d  = frame_q;
    offset_d = offset_q;
    if (accept) begin
      frame_d  = '0;
      offset_d = '0;
    end else if (!scroll_en) begin
      frame_d = '0;
    end else if (state_q != EMPTY && frame_wrap) begin
      if (frame_q == FrmW'(SCROLL_FRAMES - 1)) begin
        frame_d  = '0;
        offset_d = (offset_q == OffW'(MSG_LEN - 1)) ? '0 : offset_q + OffW'(1);
      end else begin
        frame_d = frame_q + FrmW'(1);
      end
    end
  end

  always_comb begin
    sel  = OffW'((32'(offset_q) + NUM_DIGITS - 32'd1 - 32'(digit_q)) % MSG_LEN);
    code = (state_q == EMPTY) ? CODE_DASH : sanitize_code(buf_q[sel]);
    // Slot cycle 0 keeps every anode off so the previous digit cannot ghost.
    if (blank_all || refresh_q == '0) begin
      an_d = '1;
    end else begin
      an_d = ~(NUM_DIGITS'(1) << digit_q);
    end
  end

  binaryToSegment u_dec (
    .bin (code),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      refresh_q <= '0;
      digit_q   <= DigW'(NUM_DIGITS - 1);
      frame_q   <= '0;
      offset_q  <= '0;
      ready_q   <= 1'b0;
      an_q      <= '1;
      seg_q     <= 7'b1111111;
      tick_q    <= 1'b0;
      for (int i = 0; i < MSG_LEN; i++) begin
        buf_q[i] <= CODE_BLANK;
      end
    end else begin
      state_q   <= state_d;
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
      frame_q   <= frame_d;
      offset_q  <= offset_d;
      ready_q   <= ready_d;
      an_q      <= an_d;
      seg_q     <= seg_dec;
      tick_q    <= frame_wrap;
      if (accept) begin
        for (int i = 0; i < MSG_LEN; i++) begin
          buf_q[i] <= msg_data[5*i +: 5];
        end
      end
    end
  end

  assign msg_ready  = ready_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with REFRESH_DIV=4, SCROLL_FRAMES=2.
module tb_seg_scan_controller;

  localparam int unsigned NumDigits = 4;
  localparam int unsigned MsgLen    = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   msg_valid = 1'b0;
  logic                   msg_ready;
  logic [5*MsgLen-1:0]    msg_data = '0;
  logic                   scroll_en = 1'b0;
  logic                   blank_all = 1'b0;
  logic [NumDigits-1:0]   an;
  logic [6:0]             seg;
  logic                   frame_tick;

  int unsigned cyc;
  int          checks = 0;
  int          errors = 0;
  logic [4:0]  tb_buf [MsgLen];

  seg_scan_controller #(
    .NUM_DIGITS    (NumDigits),
    .MSG_LEN       (MsgLen),
    .REFRESH_DIV   (4),
    .SCROLL_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .msg_data   (msg_data),
    .scroll_en  (scroll_en),
    .blank_all  (blank_all),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Edges since reset release; outputs seen after edge k reflect internal cycle k-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [6:0] seg_of(input logic [4:0] c);
    case (c)
      5'h00: return 7'b0000001;
      5'h01: return 7'b1001111;
      5'h02: return 7'b0010010;
      5'h03: return 7'b0000110;
      5'h04: return 7'b1001100;
      5'h05: return 7'b0100100;
      5'h06: return 7'b0100000;
      5'h07: return 7'b0001111;
      5'h10: return 7'b1110001;
      5'h11: return 7'b1000010;
      5'h12: return 7'b0011000;
      5'h13: return 7'b1101010;
      5'h14: return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int unsigned exp_digit(input int unsigned k);
    return 3 - ((k - 1) / 4) % 4;
  endfunction

  function automatic logic [3:0] exp_an(input int unsigned k);
    if ((k - 1) % 4 == 0) return 4'b1111;
    return ~(4'b0001 << exp_digit(k));
  endfunction

  function automatic logic [6:0] exp_seg(input int unsigned k, input int unsigned off);
    return seg_of(tb_buf[(off + 3 - exp_digit(k)) % MsgLen]);
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_until(input int unsigned k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic load(output int unsigned a);
    for (int i = 0; i < MsgLen; i++) msg_data[5*i +: 5] = tb_buf[i];
    msg_valid = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    a = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL rst_an: got %b want 1111", an); end
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL rst_seg: got %b want 1111111", seg); end
    checks++; if (msg_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", msg_ready); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b want 0", frame_tick); end
    rst_n = 1'b1;
    step();
    checks++; if (msg_ready !== 1'b1) begin errors++; $display("FAIL ready_rise: got %b want 1", msg_ready); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (an !== exp_an(cyc)) begin
        errors++; $display("FAIL empty_an cyc=%0d: got %b want %b", cyc, an, exp_an(cyc));
      end
      checks++;
      if (seg !== 7'b1111110) begin
        errors++; $display("FAIL empty_dash cyc=%0d: got %b want 1111110", cyc, seg);
      end
      step();
    end
  endtask

  task automatic test_load();
    int unsigned a;
    scroll_en = 1'b0;
    for (int i = 0; i < MsgLen; i++) tb_buf[i] = 5'(i);
    load(a);
    checks++; if (msg_ready !== 1'b0) begin errors++; $display("FAIL load_busy: got %b want 0", msg_ready); end
    step();
    checks++; if (msg_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b want 1", msg_ready); end
    step();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (an !== exp_an(cyc) || seg !== exp_seg(cyc, 0)) begin
        errors++; $display("FAIL load_disp cyc=%0d: got an=%b seg=%b want an=%b seg=%b",
                           cyc, an, seg, exp_an(cyc), exp_seg(cyc, 0));
      end
      step();
    end
  endtask

  task automatic test_scroll();
    int unsigned a, w2;
    scroll_en = 1'b1;
    load(a);
    w2 = (a / 16 + 2) * 16;
    wait_until(w2);
    checks++;
    if (seg !== exp_seg(cyc, 0)) begin
      errors++; $display("FAIL scroll_pre: got %b want %b", seg, exp_seg(cyc, 0));
    end
    step();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (an !== exp_an(cyc) || seg !== exp_seg(cyc, 1)) begin
        errors++; $display("FAIL scroll_1 cyc=%0d: got an=%b seg=%b want an=%b seg=%b",
                           cyc, an, seg, exp_an(cyc), exp_seg(cyc, 1));
      end
      step();
    end
    wait_until(w2 + 224);
    checks++;
    if (seg !== exp_seg(cyc, 7)) begin
      errors++; $display("FAIL scroll_7: got %b want %b", seg, exp_seg(cyc, 7));
    end
    step();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (seg !== exp_seg(cyc, 0)) begin
        errors++; $display("FAIL scroll_wrap cyc=%0d: got %b want %b", cyc, seg, exp_seg(cyc, 0));
      end
      step();
    end
  endtask

  task automatic test_sanitize();
    int unsigned a;
    scroll_en = 1'b0;
    tb_buf[0] = 5'h1F; tb_buf[1] = 5'h14; tb_buf[2] = 5'h10; tb_buf[3] = 5'h12;
    tb_buf[4] = 5'h16; tb_buf[5] = 5'h11; tb_buf[6] = 5'h13; tb_buf[7] = 5'h15;
    load(a);
    step();
    step();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (exp_digit(cyc) == 3) begin
        if (seg !== 7'b1111111) begin
          errors++; $display("FAIL sanitize_left cyc=%0d: got %b want 1111111", cyc, seg);
        end
      end else if (seg !== exp_seg(cyc, 0)) begin
        errors++; $display("FAIL sanitize_disp cyc=%0d: got %b want %b", cyc, seg, exp_seg(cyc, 0));
      end
      step();
    end
  endtask

  task automatic test_accept_on_step();
    int unsigned a, w2;
    scroll_en = 1'b1;
    for (int i = 0; i < MsgLen; i++) tb_buf[i] = 5'(i);
    load(a);
    w2 = (a / 16 + 2) * 16;
    wait_until(w2 - 1);
    msg_valid = 1'b1;
    step();
    msg_valid = 1'b0;
    checks++;
    if (cyc != w2 || msg_ready !== 1'b0) begin
      errors++; $display("FAIL race_accept: got cyc=%0d ready=%b want cyc=%0d ready=0", cyc, msg_ready, w2);
    end
    step();
    checks++;
    if (seg !== exp_seg(cyc, 0)) begin
      errors++; $display("FAIL race_offset0: got %b want %b", seg, exp_seg(cyc, 0));
    end
    wait_until(w2 + 17);
    checks++;
    if (seg !== exp_seg(cyc, 0)) begin
      errors++; $display("FAIL race_one_frame: got %b want %b", seg, exp_seg(cyc, 0));
    end
    wait_until(w2 + 32);
    checks++;
    if (seg !== exp_seg(cyc, 0)) begin
      errors++; $display("FAIL race_pre_step: got %b want %b", seg, exp_seg(cyc, 0));
    end
    step();
    checks++;
    if (seg !== exp_seg(cyc, 1)) begin
      errors++; $display("FAIL race_step: got %b want %b", seg, exp_seg(cyc, 1));
    end
  endtask

  task automatic test_blank_tick();
    blank_all = 1'b1;
    step();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (an !== 4'b1111) begin
        errors++; $display("FAIL blank_an cyc=%0d: got %b want 1111", cyc, an);
      end
      checks++;
      if (frame_tick !== (cyc % 16 == 0)) begin
        errors++; $display("FAIL tick cyc=%0d: got %b want %b", cyc, frame_tick, (cyc % 16 == 0));
      end
      step();
    end
    blank_all = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (an !== exp_an(cyc)) begin
        errors++; $display("FAIL unblank_an cyc=%0d: got %b want %b", cyc, an, exp_an(cyc));
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    while (exp_an(cyc) == 4'b1111) step();
    checks++;
    if (an !== exp_an(cyc)) begin
      errors++; $display("FAIL mid_active: got %b want %b", an, exp_an(cyc));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || msg_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got an=%b seg=%b ready=%b want 1111 1111111 0",
                         an, seg, msg_ready);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_load();
    test_scroll();
    test_sanitize();
    test_accept_on_step();
    test_blank_tick();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
